// File: rtl/demux32_1_4_fifo.sv
// One-to-four word distributor: each incoming word is steered by in_sel into a
// small per-lane FIFO with its own valid/ready handshake toward its consumer.
module demux32_1_4_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [3:0]           lane_full
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic push_any;

  // Head-of-line: only the selected lane's fullness gates the producer, and
  // in_ready never looks at out_ready so there is no consumer-to-producer path.
  assign in_ready = !rst && !lane_full[in_sel];
  assign push_any = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [AW:0]      count_q, count_d;
      logic             push;
      logic             pop;

      assign push = push_any && (in_sel == 2'(gi));
      assign pop  = out_valid[gi] && out_ready[gi];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
        if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
        case ({push, pop})
          2'b10:   count_d = count_q + ONE_CNT;
          2'b01:   count_d = count_q - ONE_CNT;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage has no reset; push is already blocked while rst is high.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
      end

      assign out_valid[gi]                = (count_q != '0);
      assign lane_full[gi]                = (count_q == FULL_CNT);
      assign out_data[gi*WIDTH +: WIDTH]  = out_valid[gi] ? mem_q[rd_ptr_q] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_demux32_1_4_fifo.sv
// Directed bench for demux32_1_4_fifo: hand-computed expectations for reset,
// routing, full/stall, simultaneous push/pop across the wrap, and reset priority.
module tb_demux32_1_4_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     in_data;
  logic [1:0]           in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*WIDTH-1:0]   out_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [3:0]           lane_full;

  int tests_run;
  int tests_failed;

  demux32_1_4_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_full (lane_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [WIDTH-1:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    chk("in_ready_during_rst", {127'd0, in_ready}, 128'd0);
    step();
    step();
    chk("rst_out_valid", {124'd0, out_valid}, 128'd0);
    chk("rst_lane_full", {124'd0, lane_full}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("idle_in_ready_sel%0d", s), {127'd0, in_ready}, 128'd1);
    end

    // Single push to lane 2
    push(2'd2, 32'h1111_1111);
    chk("p1_out_valid", {124'd0, out_valid}, 128'h4);
    chk("p1_lane2", {96'd0, lane(2)}, 128'h1111_1111);
    chk("p1_lane0", {96'd0, lane(0)}, 128'd0);
    chk("p1_lane1", {96'd0, lane(1)}, 128'd0);
    chk("p1_lane3", {96'd0, lane(3)}, 128'd0);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    chk("p1_drained", {124'd0, out_valid}, 128'd0);

    // Fill lane 1, check stall, then drain
    push(2'd1, 32'hAAAA_0001);
    push(2'd1, 32'hAAAA_0002);
    chk("full_lane_full", {124'd0, lane_full}, 128'h2);
    in_sel = 2'd1;
    #1;
    chk("full_in_ready_sel1", {127'd0, in_ready}, 128'd0);
    in_sel = 2'd0;
    #1;
    chk("full_in_ready_sel0", {127'd0, in_ready}, 128'd1);
    push(2'd1, 32'hAAAA_0003);
    chk("full_head_kept", {96'd0, lane(1)}, 128'hAAAA_0001);
    chk("full_still_full", {124'd0, lane_full}, 128'h2);
    out_ready = 4'b0010;
    step();
    chk("drain_word2", {96'd0, lane(1)}, 128'hAAAA_0002);
    chk("drain_valid2", {124'd0, out_valid}, 128'h2);
    step();
    out_ready = 4'b0000;
    chk("drain_empty", {124'd0, out_valid}, 128'd0);

    // Lane 3 streaming with simultaneous push/pop across the pointer wrap
    push(2'd3, 32'h0000_00B0);
    out_ready = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stream_head%0d", k), {96'd0, lane(3)}, 128'(32'hB0 + k));
      chk($sformatf("stream_valid%0d", k), {124'd0, out_valid}, 128'h8);
      chk($sformatf("stream_notfull%0d", k), {124'd0, lane_full}, 128'd0);
      in_sel   = 2'd3;
      in_data  = 32'hB1 + 32'(k);
      in_valid = (k < 4);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("stream_end_empty", {124'd0, out_valid}, 128'd0);

    // All four lanes pop together
    for (int k = 0; k < 4; k++) push(2'(k), 32'hC000_0000 + 32'(k));
    chk("all4_valid", {124'd0, out_valid}, 128'hF);
    chk("all4_data", out_data, {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    chk("all4_popped", {124'd0, out_valid}, 128'd0);

    // Lane 0 full, reset while a push is offered
    push(2'd0, 32'h0000_00D0);
    push(2'd0, 32'h0000_00D1);
    chk("rstx_full", {124'd0, lane_full}, 128'h1);
    rst      = 1'b1;
    in_sel   = 2'd0;
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    out_ready = 4'b0001;
    #1;
    chk("rstx_in_ready", {127'd0, in_ready}, 128'd0);
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("rstx_out_valid", {124'd0, out_valid}, 128'd0);
    chk("rstx_lane_full", {124'd0, lane_full}, 128'd0);
    chk("rstx_out_data", out_data, 128'd0);

    // Pops on empty lanes are ignored; a fresh push becomes the head
    out_ready = 4'b1111;
    step();
    step();
    chk("underflow_none", {124'd0, out_valid}, 128'd0);
    out_ready = 4'b0000;
    push(2'd0, 32'h0000_00E0);
    chk("after_rst_valid", {124'd0, out_valid}, 128'h1);
    chk("after_rst_head", {96'd0, lane(0)}, 128'hE0);
    chk("after_rst_notfull", {124'd0, lane_full}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
